// File: rtl/exec_pkg.sv
// exec_pkg: shared widths, opcode and FSM state encodings for exec_unit
package exec_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL} op_e;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_MUL, S_WB} state_e;
endpackage

// File: rtl/mul_seq.sv
// mul_seq: sequential unsigned shift-add multiplier, one multiplier bit per cycle
// Ports: clk, rst_n (async active-low); i_start loads i_a/i_b; o_done is high in the
// cycle of the final step and o_prod then carries the full 2*DATA_W product.
module mul_seq #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic                  o_done,
  output logic [2*DATA_W-1:0]   o_prod
);
  localparam int CW = $clog2(DATA_W);
  logic [2*DATA_W-1:0] r_acc, r_mcand, w_acc_nxt;
  logic [DATA_W-1:0]   r_mplier;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  // o_prod exposes the post-step accumulator so the caller can latch it on the done edge
  assign o_done = r_busy && r_cnt == CW'(DATA_W - 1);
  assign o_prod = w_acc_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{DATA_W{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      r_busy   <= !o_done;
    end
  end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: single-issue execute unit (IDLE/READ/MUL/WB) with register-file port
// Ports: clk, rst_n (async active-low); instr_* handshake and fields; rf_addr_rd1/2 and
// rf_data1/2 read the register file; rf_we/rf_addr_wr/rf_data_wr write it; busy and
// flag_zero/flag_carry report status of the last written-back result.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  output logic [ADDR_W-1:0] rf_addr_rd1,
  output logic [ADDR_W-1:0] rf_addr_rd2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr_wr,
  output logic [DATA_W-1:0] rf_data_wr,
  output logic              busy,
  output logic              flag_zero,
  output logic              flag_carry
);
  state_e              r_state, w_nxt;
  op_e                 r_op;
  logic [ADDR_W-1:0]   r_rd, r_rs1, r_rs2;
  logic [DATA_W-1:0]   r_res, w_alu;
  logic                r_cout, w_cout, r_zero, r_carry;
  logic                w_mul_done;
  logic [2*DATA_W-1:0] w_prod;
  // reset holds the state at IDLE, so ready is also gated by rst_n
  assign instr_ready = rst_n && r_state == S_IDLE;
  assign busy        = r_state != S_IDLE;
  assign rf_we       = r_state == S_WB;
  assign rf_addr_wr  = r_rd;
  assign rf_data_wr  = r_res;
  assign rf_addr_rd1 = r_rs1;
  assign rf_addr_rd2 = r_rs2;
  assign flag_zero   = r_zero;
  assign flag_carry  = r_carry;
  always_comb begin
    w_alu  = '0;
    w_cout = 1'b0;
    case (r_op)
      OP_ADD: {w_cout, w_alu} = {1'b0, rf_data1} + {1'b0, rf_data2};
      OP_SUB: begin
        w_alu  = rf_data1 - rf_data2;
        w_cout = rf_data1 < rf_data2;
      end
      OP_AND: w_alu = rf_data1 & rf_data2;
      OP_OR:  w_alu = rf_data1 | rf_data2;
      OP_XOR: w_alu = rf_data1 ^ rf_data2;
      OP_SHL: w_alu = rf_data1 << rf_data2[3:0];
      OP_SHR: w_alu = rf_data1 >> rf_data2[3:0];
      default: w_alu = '0;
    endcase
  end
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  w_nxt = instr_valid ? S_READ : S_IDLE;
      S_READ:  w_nxt = r_op == OP_MUL ? S_MUL : S_WB;
      S_MUL:   w_nxt = w_mul_done ? S_WB : S_MUL;
      default: w_nxt = S_IDLE;
    endcase
  end
  mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (r_state == S_READ && r_op == OP_MUL),
    .i_a     (rf_data1),
    .i_b     (rf_data2),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_ADD;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE && instr_valid) begin
        r_op  <= op_e'(instr_op);
        r_rd  <= instr_rd;
        r_rs1 <= instr_rs1;
        r_rs2 <= instr_rs2;
      end
      if (r_state == S_READ) begin
        r_res  <= w_alu;
        r_cout <= w_cout;
      end
      if (r_state == S_MUL && w_mul_done) begin
        r_res  <= w_prod[DATA_W-1:0];
        r_cout <= |w_prod[2*DATA_W-1:DATA_W];
      end
      if (r_state == S_WB) begin
        r_zero  <= r_res == '0;
        r_carry <= r_cout;
      end
    end
  end
endmodule
